// File: rtl/id_ex_alu_reg.sv
// ID/EX pipeline register with ALU-control decode.
// Captures operands and write control from ID and decodes aluOp/funct into
// the slice mux select, B inversion, carry-in and set-less-than controls.
// Priority per edge: rst > flush > stall > load.
module id_ex_alu_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  aluOp,
  input  logic [5:0]  funct,
  input  logic [31:0] rsData,
  input  logic [31:0] rtData,
  input  logic [31:0] imm,
  input  logic        aluSrc,
  input  logic        regWrite,
  input  logic [4:0]  rdAddr,
  output logic        out_valid,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic [1:0]  sel,
  output logic        invertB,
  output logic        cin0,
  output logic        sltOp,
  output logic        regWrite_q,
  output logic [4:0]  rdAddr_q,
  output logic        illegal,
  output logic [7:0]  illegalCnt
);

  // EX-side register contents; all-zero is the bubble
  typedef struct packed {
    logic        vld;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sel;
    logic        inv;
    logic        slt;
    logic        rw;
    logic [4:0]  rd;
    logic        ill;
  } ex_t;

  ex_t        ex_q, ex_d;
  logic [7:0] cnt_q, cnt_d;

  logic [1:0] dec_sel;
  logic       dec_inv, dec_slt, dec_ill;

  // ALU-control decode; unknown ops fall back to bubble controls
  always_comb begin
    dec_sel = 2'b00;
    dec_inv = 1'b0;
    dec_slt = 1'b0;
    dec_ill = 1'b0;
    unique case (aluOp)
      2'b00: dec_sel = 2'b10;
      2'b01: begin dec_sel = 2'b11; dec_inv = 1'b1; end
      2'b10: begin
        case (funct)
          6'b100100: dec_sel = 2'b00;
          6'b100101: dec_sel = 2'b01;
          6'b100000: dec_sel = 2'b10;
          6'b100010: begin dec_sel = 2'b11; dec_inv = 1'b1; end
          6'b101010: begin dec_sel = 2'b11; dec_inv = 1'b1; dec_slt = 1'b1; end
          default:   dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Next-state: flush beats stall beats load; counter only moves on load
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d.vld = in_valid;
      ex_d.a   = rsData;
      ex_d.b   = aluSrc ? imm : rtData;
      ex_d.sel = dec_sel;
      ex_d.inv = dec_inv;
      ex_d.slt = dec_slt;
      ex_d.rw  = regWrite & in_valid & ~dec_ill;
      ex_d.rd  = rdAddr;
      ex_d.ill = in_valid & dec_ill;
      if (in_valid && dec_ill && cnt_q != 8'hFF)
        cnt_d = cnt_q + 8'd1;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid  = ex_q.vld;
  assign dataA      = ex_q.a;
  assign dataB      = ex_q.b;
  assign sel        = ex_q.sel;
  assign invertB    = ex_q.inv;
  assign cin0       = ex_q.inv;
  assign sltOp      = ex_q.slt;
  assign regWrite_q = ex_q.rw;
  assign rdAddr_q   = ex_q.rd;
  assign illegal    = ex_q.ill;
  assign illegalCnt = cnt_q;

endmodule

// File: tb/tb_id_ex_alu_reg.sv
// Bench for id_ex_alu_reg: decode vector table, directed stall/flush/reset
// sequences, and randomized traffic against a behavioural reference model.
module tb_id_ex_alu_reg;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush, aluSrc, regWrite;
  logic [1:0]  aluOp;
  logic [5:0]  funct;
  logic [31:0] rsData, rtData, imm;
  logic [4:0]  rdAddr;
  logic        out_valid, invertB, cin0, sltOp, regWrite_q, illegal;
  logic [31:0] dataA, dataB;
  logic [1:0]  sel;
  logic [4:0]  rdAddr_q;
  logic [7:0]  illegalCnt;

  int errors = 0;
  int checks = 0;

  id_ex_alu_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .aluOp(aluOp), .funct(funct), .rsData(rsData), .rtData(rtData), .imm(imm),
    .aluSrc(aluSrc), .regWrite(regWrite), .rdAddr(rdAddr),
    .out_valid(out_valid), .dataA(dataA), .dataB(dataB), .sel(sel),
    .invertB(invertB), .cin0(cin0), .sltOp(sltOp), .regWrite_q(regWrite_q),
    .rdAddr_q(rdAddr_q), .illegal(illegal), .illegalCnt(illegalCnt)
  );

  always #5 clk = ~clk;

  // Reference model state (expected outputs)
  logic        m_ov, m_inv, m_slt, m_rw, m_ill;
  logic [31:0] m_a, m_b;
  logic [1:0]  m_sel;
  logic [4:0]  m_rd;
  int          m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Mnemonic-level decode: which ALU operation the instruction names
  task automatic decode(input logic [1:0] op, input logic [5:0] f,
                        output bit ok, output logic [1:0] s, output bit inv, output bit slt);
    string mn;
    ok = 1; slt = 0;
    if (op == 2'd0) mn = "add";
    else if (op == 2'd1) mn = "sub";
    else if (op == 2'd3) mn = "bad";
    else if (f == 6'h24) mn = "and";
    else if (f == 6'h25) mn = "or";
    else if (f == 6'h20) mn = "add";
    else if (f == 6'h22) mn = "sub";
    else if (f == 6'h2A) mn = "slt";
    else mn = "bad";
    case (mn)
      "and": begin s = 2'd0; inv = 0; end
      "or":  begin s = 2'd1; inv = 0; end
      "add": begin s = 2'd2; inv = 0; end
      "sub": begin s = 2'd3; inv = 1; end
      "slt": begin s = 2'd3; inv = 1; slt = 1; end
      default: begin ok = 0; s = 2'd0; inv = 0; end
    endcase
  endtask

  // Apply one clock edge to the model using the current inputs
  task automatic model_edge();
    bit ok, inv, slt;
    logic [1:0] s;
    if (rst) begin
      {m_ov, m_inv, m_slt, m_rw, m_ill, m_a, m_b, m_sel, m_rd} = '0;
      m_cnt = 0;
    end else if (flush) begin
      {m_ov, m_inv, m_slt, m_rw, m_ill, m_a, m_b, m_sel, m_rd} = '0;
    end else if (!stall) begin
      decode(aluOp, funct, ok, s, inv, slt);
      m_ov  = in_valid;
      m_a   = rsData;
      m_b   = aluSrc ? imm : rtData;
      m_sel = s; m_inv = inv; m_slt = slt;
      m_rw  = regWrite && in_valid && ok;
      m_rd  = rdAddr;
      m_ill = in_valid && !ok;
      if (in_valid && !ok && m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".dataA"}, dataA, m_a);
    chk({tag, ".dataB"}, dataB, m_b);
    chk({tag, ".sel"}, 32'(sel), 32'(m_sel));
    chk({tag, ".invertB"}, 32'(invertB), 32'(m_inv));
    chk({tag, ".cin0"}, 32'(cin0), 32'(m_inv));
    chk({tag, ".sltOp"}, 32'(sltOp), 32'(m_slt));
    chk({tag, ".regWrite_q"}, 32'(regWrite_q), 32'(m_rw));
    chk({tag, ".rdAddr_q"}, 32'(rdAddr_q), 32'(m_rd));
    chk({tag, ".illegal"}, 32'(illegal), 32'(m_ill));
    chk({tag, ".illegalCnt"}, 32'(illegalCnt), 32'(m_cnt));
  endtask

  // One edge: model advances, DUT sampled 1 time unit after the edge
  task automatic step(input string tag);
    model_edge();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic v, input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] im,
                        input logic src, input logic rw, input logic [4:0] rd);
    in_valid = v; aluOp = op; funct = f; rsData = rs; rtData = rt; imm = im;
    aluSrc = src; regWrite = rw; rdAddr = rd;
  endtask

  typedef struct {
    logic v; logic [1:0] op; logic [5:0] f; logic [31:0] rs, rt, im;
    logic src, rw; logic [4:0] rd;
    logic e_ov; logic [1:0] e_sel; logic e_inv, e_slt, e_ill, e_rw; logic [31:0] e_b;
  } vec_t;

  vec_t vt[12];

  initial begin
    //          v op     f      rs       rt  imm          src rw rd   ov sel inv slt ill rw  dataB
    vt[0]  = '{1, 2'd2, 6'h22, 32'd7,    3,  32'd99,      0, 1, 5,   1, 3, 1, 0, 0, 1, 32'd3};
    vt[1]  = '{1, 2'd0, 6'h3F, 32'h1000, 8,  32'hFFFFFFFC,1, 1, 9,   1, 2, 0, 0, 0, 1, 32'hFFFFFFFC};
    vt[2]  = '{1, 2'd1, 6'h3F, 32'd1,    2,  32'd3,       0, 0, 0,   1, 3, 1, 0, 0, 0, 32'd2};
    vt[3]  = '{1, 2'd2, 6'h24, 32'hF0,   32'h0F, 0,       0, 1, 1,   1, 0, 0, 0, 0, 1, 32'h0F};
    vt[4]  = '{1, 2'd2, 6'h25, 32'hA,    32'h5, 0,        0, 1, 2,   1, 1, 0, 0, 0, 1, 32'h5};
    vt[5]  = '{1, 2'd2, 6'h20, 32'd5,    32'd6, 32'd1,    1, 1, 3,   1, 2, 0, 0, 0, 1, 32'd1};
    vt[6]  = '{1, 2'd2, 6'h2A, 32'd1,    32'd2, 0,        0, 1, 4,   1, 3, 1, 1, 0, 1, 32'd2};
    vt[7]  = '{1, 2'd3, 6'h20, 32'd1,    32'd2, 0,        0, 1, 6,   1, 0, 0, 0, 1, 0, 32'd2};
    vt[8]  = '{1, 2'd2, 6'h00, 32'd1,    32'd2, 0,        0, 1, 7,   1, 0, 0, 0, 1, 0, 32'd2};
    vt[9]  = '{0, 2'd2, 6'h20, 32'd8,    32'd9, 0,        0, 1, 8,   0, 2, 0, 0, 0, 0, 32'd9};
    vt[10] = '{0, 2'd3, 6'h00, 32'd8,    32'd9, 0,        0, 1, 8,   0, 0, 0, 0, 0, 0, 32'd9};
    vt[11] = '{1, 2'd2, 6'h20, 32'd3,    32'd4, 0,        0, 0, 10,  1, 2, 0, 0, 0, 0, 32'd4};

    rst = 1; stall = 0; flush = 0;
    set_in(1, 2'd2, 6'h20, 32'd11, 32'd22, 32'd33, 0, 1, 5'd7);

    // Reset held for several edges: outputs stay zero
    step("rst0");
    step("rst1");
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.dataA", dataA, 0);
    chk("rst.illegalCnt", 32'(illegalCnt), 0);
    rst = 0;
    step("first_load");
    chk("first_load.dataA", dataA, 32'd11);

    // Decode table
    for (int i = 0; i < 12; i++) begin
      set_in(vt[i].v, vt[i].op, vt[i].f, vt[i].rs, vt[i].rt, vt[i].im, vt[i].src, vt[i].rw, vt[i].rd);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.ov", i), 32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("vec%0d.sel", i), 32'(sel), 32'(vt[i].e_sel));
      chk($sformatf("vec%0d.inv", i), 32'(invertB), 32'(vt[i].e_inv));
      chk($sformatf("vec%0d.cin0", i), 32'(cin0), 32'(vt[i].e_inv));
      chk($sformatf("vec%0d.slt", i), 32'(sltOp), 32'(vt[i].e_slt));
      chk($sformatf("vec%0d.ill", i), 32'(illegal), 32'(vt[i].e_ill));
      chk($sformatf("vec%0d.rw", i), 32'(regWrite_q), 32'(vt[i].e_rw));
      chk($sformatf("vec%0d.dataA", i), dataA, vt[i].rs);
      chk($sformatf("vec%0d.dataB", i), dataB, vt[i].e_b);
    end

    // SLT then 3 stalled edges with changing inputs, then resume
    set_in(1, 2'd2, 6'h2A, 32'd5, 32'd6, 0, 0, 1, 5'd12);
    step("slt");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 2'd0, 6'h00, 32'(i + 100), 32'(i + 200), 32'd1, 1, 1, 5'd20);
      step($sformatf("stall%0d", i));
      chk($sformatf("stall%0d.sel", i), 32'(sel), 3);
      chk($sformatf("stall%0d.inv", i), 32'(invertB), 1);
      chk($sformatf("stall%0d.slt", i), 32'(sltOp), 1);
      chk($sformatf("stall%0d.dataA", i), dataA, 32'd5);
    end
    stall = 0;
    step("resume");
    chk("resume.sel", 32'(sel), 2);
    chk("resume.dataA", dataA, 32'd102);

    // Flush with simultaneous stall over a live ADD
    set_in(1, 2'd2, 6'h20, 32'd40, 32'd2, 0, 0, 1, 5'd3);
    step("add_live");
    flush = 1; stall = 1;
    step("flush_stall");
    chk("flush_stall.ov", 32'(out_valid), 0);
    chk("flush_stall.rw", 32'(regWrite_q), 0);
    chk("flush_stall.dataA", dataA, 0);
    chk("flush_stall.dataB", dataB, 0);
    flush = 0; stall = 0;

    // Saturating illegal counter
    rst = 1; step("cnt_rst"); rst = 0;
    set_in(1, 2'd2, 6'h00, 32'd1, 32'd1, 0, 0, 1, 5'd1);
    for (int i = 0; i < 300; i++) begin
      model_edge();
      @(posedge clk); #1;
      chk("sat.illegal", 32'(illegal), 1);
      chk("sat.rw", 32'(regWrite_q), 0);
      chk("sat.cnt", 32'(illegalCnt), (i + 1 > 255) ? 255 : i + 1);
    end
    check_all("sat_end");
    rst = 1; step("sat_rst");
    chk("sat_rst.cnt", 32'(illegalCnt), 0);
    rst = 0;

    // Reset during a stalled OR, then release with AND
    set_in(1, 2'd2, 6'h25, 32'd3, 32'd4, 0, 0, 1, 5'd9);
    step("or_load");
    stall = 1; step("or_stall");
    rst = 1; step("or_rst");
    chk("or_rst.sel", 32'(sel), 0);
    chk("or_rst.ov", 32'(out_valid), 0);
    rst = 0; stall = 0;
    set_in(1, 2'd2, 6'h24, 32'd6, 32'd7, 0, 0, 1, 5'd2);
    step("and_after_rst");
    chk("and_after_rst.sel", 32'(sel), 0);
    chk("and_after_rst.ov", 32'(out_valid), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [5:0] fl[5];
      int k;
      fl = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A};
      k = $urandom_range(0, 6);
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 4) == 0);
      set_in(1'($urandom), 2'($urandom), (k < 5) ? fl[k] : 6'($urandom), $urandom, $urandom,
             $urandom, 1'($urandom), 1'($urandom), 5'($urandom));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_reg.md
ID_EX_ALU_REG -- requirements
Module: id_ex_alu_reg

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  reset; one clock, reset synchronous and active-high.
REQ-003 SHALL have ports: in_valid  in  1  ID stage presents an instruction.
REQ-004 SHALL have ports: stall  in  1  hold EX-side registers (hazard unit).
REQ-005 SHALL have ports: flush  in  1  replace EX-side contents with a bubble (branch/hazard).
REQ-006 SHALL have ports: aluOp  in  2  00 = add (lw/sw), 01 = sub (beq), 10 = R-type per funct, 11 = reserved.
REQ-007 SHALL have ports: funct  in  6  R-type function field.
REQ-008 SHALL have ports: rsData, rtData, imm  in  32 each  register operands and sign-extended immediate.
REQ-009 SHALL have ports: aluSrc  in  1  1 = dataB takes imm, 0 = rtData.
REQ-010 SHALL have ports: regWrite  in  1; rdAddr  in  5  destination write control and address.
REQ-011 SHALL have ports: out_valid  out  1  EX stage holds a live instruction.
REQ-012 SHALL have ports: dataA, dataB  out  32 each  ALU operands.
REQ-013 SHALL have ports: sel  out  2  slice result mux: 00 AND, 01 OR, 10 add, 11 sub.
REQ-014 SHALL have ports: invertB  out  1; cin0  out  1  carry into bit-0 slice, always equal to invertB.
REQ-015 SHALL have ports: sltOp  out  1  EX replaces result with {31'b0, sign of subtraction}.
REQ-016 SHALL have ports: regWrite_q  out  1; rdAddr_q  out  5  registered write control.
REQ-017 SHALL have ports: illegal  out  1  registered instruction had an undecodable op.
REQ-018 SHALL have ports: illegalCnt  out  8  saturating count of illegal instructions accepted.

Function
REQ-019 All outputs SHALL be registered; latency in -> out is exactly one clk edge when loaded.
REQ-020 Update priority per edge SHALL be: rst > flush > stall > load.
REQ-021 Load (no rst, flush, stall) SHALL capture all fields; out_valid <= in_valid.
REQ-022 stall without flush SHALL hold every output, including illegalCnt.
REQ-023 flush SHALL force bubble: out_valid 0, regWrite_q 0, illegal 0, sel 00, invertB 0, cin0 0, sltOp 0, dataA/dataB/rdAddr_q 0; flush overrides simultaneous stall.
REQ-024 Decode for aluOp 10: funct 100100 -> sel 00, inv 0; 100101 -> 01, 0; 100000 -> 10, 0; 100010 -> 11, 1; 101010 -> 11, 1, sltOp 1.
REQ-025 aluOp 00 SHALL decode as add (10, 0); aluOp 01 as sub (11, 1); sltOp 0 for both; funct ignored.
REQ-026 aluOp 11, or aluOp 10 with any other funct, SHALL be illegal: load as bubble controls (sel 00, inv 0, sltOp 0, regWrite_q 0) with illegal 1 and out_valid = in_valid.
REQ-027 dataA SHALL be rsData; dataB SHALL be aluSrc ? imm : rtData; no width change.
REQ-028 regWrite_q SHALL equal regWrite & in_valid & ~illegal_decode on load.
REQ-029 illegalCnt SHALL increment by 1 on a load with in_valid = 1 and illegal decode; saturate at 255 (no wrap).
REQ-030 in_valid 0 on load SHALL produce out_valid 0, regWrite_q 0, illegal 0; other fields still captured, no count.

Reset
REQ-031 On rst high at clk edge all outputs SHALL be 0, including illegalCnt; rst mid-stall or mid-flush SHALL win.
REQ-032 Outputs SHALL remain 0 while rst held; first load occurs on the first edge with rst low.

Verification
REQ-033 R-type SUB: aluOp 10, funct 100010, rs 7, rt 3, aluSrc 0 -> next edge sel 11, invertB 1, cin0 1, dataA 7, dataB 3, out_valid 1.
REQ-034 lw: aluOp 00, rs 0x1000, imm 0xFFFFFFFC, aluSrc 1 -> sel 10, invertB 0, dataB 0xFFFFFFFC, sltOp 0.
REQ-035 SLT then stall 3 cycles: outputs frozen at sel 11, invertB 1, sltOp 1 while inputs change; load resumes on 4th edge.
REQ-036 flush and stall together with live ADD latched -> next edge out_valid 0, regWrite_q 0, all data 0.
REQ-037 300 consecutive illegal funct 000000 with in_valid 1 -> illegal 1 each, regWrite_q 0, illegalCnt stops at 255; rst -> 0.
REQ-038 rst asserted during a stalled OR instruction -> next edge all outputs 0; release with AND input -> sel 00 one edge later.
